// File: rtl/lut_neuron_stream_if.sv
// Sample stream into the neuron and result stream out of it.
// The slave side is the neuron; the master side is whoever feeds it
// samples and drains its results.
interface lut_neuron_stream_if #(
  parameter int ADDR_W   = 8,
  parameter int OUT_BITS = 2
);
  logic [ADDR_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/lut_neuron_stream.sv
// Runtime-programmable LUT neuron. The table is loaded in CFG, then applied to
// a valid/ready sample stream through a two-stage pipeline. A reconfiguration
// request drains the pipeline before the table may be written again.
module lut_neuron_stream #(
  parameter int FAN_IN   = 4,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2,
  parameter int COUNT_W  = 16,
  localparam int ADDR_W  = FAN_IN * IN_BITS,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  lut_neuron_stream_if.slave  s,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_done,
  input  logic                cfg_req,
  output logic                cfg_mode,
  output logic                cfg_err,
  output logic [COUNT_W-1:0]  sample_count
);

  typedef enum logic [1:0] {ST_CFG, ST_RUN, ST_DRAIN} state_t;

  state_t state, state_nxt;

  // Distributed RAM: deliberately not reset so contents survive rst_n.
  logic [OUT_BITS-1:0] table_mem [DEPTH];

  logic              s1_v;
  logic [ADDR_W-1:0] s1_addr;
  logic              s2_v;
  logic              adv1, adv2, accept, deliver;

  // Stage 2 moves when empty or when the consumer takes its result;
  // stage 1 moves when empty or when stage 2 moves.
  assign adv2       = !s2_v || s.out_ready;
  assign adv1       = !s1_v || adv2;
  assign s.in_ready = (state == ST_RUN) && adv1;
  assign accept     = s.in_valid && s.in_ready;
  assign deliver    = s2_v && s.out_ready;
  assign s.out_valid = s2_v;
  assign cfg_mode   = (state == ST_CFG);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CFG;
    else        state <= state_nxt;
  end

  // Next state: CFG -> RUN on cfg_done, RUN -> DRAIN on cfg_req,
  // DRAIN -> CFG once both stages are empty.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CFG:   if (cfg_done)      state_nxt = ST_RUN;
      ST_RUN:   if (cfg_req)       state_nxt = ST_DRAIN;
      ST_DRAIN: if (!s1_v && !s2_v) state_nxt = ST_CFG;
      default:  state_nxt = ST_CFG;
    endcase
  end

  // Table writes only land in CFG, where the pipeline is known empty,
  // so lookups never race a write.
  always_ff @(posedge clk) begin
    if (cfg_we && state == ST_CFG) table_mem[cfg_addr] <= cfg_data;
  end

  // Write attempts outside CFG are flagged until the next accepted cfg_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cfg_err <= 1'b0;
    else if (state == ST_CFG && cfg_done)    cfg_err <= 1'b0;
    else if (state != ST_CFG && cfg_we)      cfg_err <= 1'b1;
  end

  // Stage 1: capture the packed input address on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_addr <= '0;
    end else if (adv1) begin
      s1_v <= accept;
      if (accept) s1_addr <= s.in_data;
    end
  end

  // Stage 2: table lookup. out_data only changes when a real sample moves
  // in, so it holds under backpressure and across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v       <= 1'b0;
      s.out_data <= '0;
    end else if (adv2) begin
      s2_v <= s1_v;
      if (s1_v) s.out_data <= table_mem[s1_addr];
    end
  end

  // Delivered-result counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sample_count <= '0;
    else if (deliver) sample_count <= sample_count + COUNT_W'(1);
  end

endmodule

// File: tb/tb_lut_neuron_stream.sv
// Bench for lut_neuron_stream: default-size instance for the functional
// scenarios plus a FAN_IN=3/IN_BITS=3/OUT_BITS=4/COUNT_W=8 instance for the
// full-address sweep. Expected results come from table arrays kept here.
module tb_lut_neuron_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A (defaults) ----------------
  lut_neuron_stream_if #(.ADDR_W(8), .OUT_BITS(2)) ia ();
  logic        a_we = 0, a_done = 0, a_req = 0;
  logic [7:0]  a_addr = 0;
  logic [1:0]  a_data = 0;
  logic        a_mode, a_err;
  logic [15:0] a_cnt;

  lut_neuron_stream dut_a (
    .clk(clk), .rst_n(rst_n), .s(ia),
    .cfg_we(a_we), .cfg_addr(a_addr), .cfg_data(a_data),
    .cfg_done(a_done), .cfg_req(a_req),
    .cfg_mode(a_mode), .cfg_err(a_err), .sample_count(a_cnt)
  );

  // ---------------- instance B (sweep) ----------------
  lut_neuron_stream_if #(.ADDR_W(9), .OUT_BITS(4)) ib ();
  logic        b_we = 0, b_done = 0, b_req = 0;
  logic [8:0]  b_addr = 0;
  logic [3:0]  b_data = 0;
  logic        b_mode, b_err;
  logic [7:0]  b_cnt;

  lut_neuron_stream #(.FAN_IN(3), .IN_BITS(3), .OUT_BITS(4), .COUNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(ib),
    .cfg_we(b_we), .cfg_addr(b_addr), .cfg_data(b_data),
    .cfg_done(b_done), .cfg_req(b_req),
    .cfg_mode(b_mode), .cfg_err(b_err), .sample_count(b_cnt)
  );

  // ---------------- reference model ----------------
  logic [1:0] tbl_a [256];
  logic [3:0] tbl_b [512];
  bit         a_in_cfg;   // model's belief that A accepts table writes

  logic [7:0] a_smp  [$];
  logic [1:0] a_got  [$];
  int         a_acc  [$];
  int         a_outc [$];
  bit         a_hold_ok, a_saw_block;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_a(input logic [7:0] addr, input logic [1:0] data);
    a_we = 1; a_addr = addr; a_data = data;
    tick();
    a_we = 0;
    if (a_in_cfg) tbl_a[addr] = data;
  endtask

  task automatic pulse_done_a();
    a_done = 1; tick(); a_done = 0;
    a_in_cfg = 0;
  endtask

  // Streams a_smp through A, out_ready low for cycles [stall_at, stall_at+stall_len).
  task automatic run_stream(input int stall_at, input int stall_len);
    int idx = 0, cyc = 0, n;
    bit prev_hold = 0;
    logic [1:0] prev = 0;
    n = a_smp.size();
    a_got.delete(); a_acc.delete(); a_outc.delete();
    a_hold_ok = 1; a_saw_block = 0;
    while ((idx < n || a_got.size() < n) && cyc < 300) begin
      ia.in_valid  = (idx < n);
      ia.in_data   = (idx < n) ? a_smp[idx] : 8'h00;
      ia.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (prev_hold && ia.out_data !== prev) a_hold_ok = 0;
      prev_hold = ia.out_valid && !ia.out_ready;
      prev = ia.out_data;
      if (ia.in_valid && !ia.in_ready) a_saw_block = 1;
      if (ia.in_valid && ia.in_ready) begin a_acc.push_back(cyc); idx++; end
      if (ia.out_valid && ia.out_ready) begin
        a_got.push_back(ia.out_data); a_outc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
    end
    ia.in_valid = 0;
    ia.out_ready = 1;
  endtask

  // Loads two samples into A with out_ready low so both stages are full.
  task automatic feed_two_stalled(input logic [7:0] d0, input logic [7:0] d1, output bit ok);
    int acc = 0;
    ia.out_ready = 0;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      ia.in_valid = 1;
      ia.in_data  = (acc == 0) ? d0 : d1;
      #1;
      if (ia.in_ready) acc++;
      @(posedge clk); #1;
    end
    ia.in_valid = 0;
    ok = (acc == 2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    ia.in_valid = 0; ia.in_data = 0; ia.out_ready = 1;
    ib.in_valid = 0; ib.in_data = 0; ib.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b0 || ia.out_data !== 2'b00) begin
      errors++;
      $display("FAIL reset_stream got valid=%b ready=%b data=%h want 0 0 0",
               ia.out_valid, ia.in_ready, ia.out_data);
    end
    checks++;
    if (a_mode !== 1'b1 || a_err !== 1'b0 || a_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctrl got mode=%b err=%b cnt=%0d want 1 0 0", a_mode, a_err, a_cnt);
    end
    checks++;
    if (b_mode !== 1'b1 || b_cnt !== 8'd0 || ib.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got mode=%b cnt=%0d valid=%b want 1 0 0", b_mode, b_cnt, ib.out_valid);
    end
    @(negedge clk); rst_n = 1;
    tick();
    a_in_cfg = 1;
  endtask

  task automatic test_basic();
    logic [7:0] stim [5] = '{8'h00, 8'hE2, 8'hC3, 8'hF7, 8'hFF};
    logic [1:0] lit  [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int a = 0; a < 256; a++)
      write_a(8'(a), (a == 8'hE2 || a == 8'hC3 || a == 8'hF7) ? 2'd1 : 2'd0);
    pulse_done_a();
    checks++;
    if (a_mode !== 1'b0) begin
      errors++; $display("FAIL basic_run_mode got %b want 0", a_mode);
    end
    a_smp.delete();
    foreach (stim[i]) a_smp.push_back(stim[i]);
    run_stream(-1, 0);
    checks++;
    if (a_got.size() != 5) begin
      errors++; $display("FAIL basic_count got %0d results want 5", a_got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (a_got[i] !== tbl_a[stim[i]] || a_got[i] !== lit[i]) begin
          errors++;
          $display("FAIL basic_data[%0d] got %0d want %0d", i, a_got[i], lit[i]);
        end
      end
      checks++;
      if (a_outc[0] - a_acc[0] != 2) begin
        errors++; $display("FAIL basic_latency got %0d want 2", a_outc[0] - a_acc[0]);
      end
      checks++;
      if (a_outc[4] - a_outc[0] != 4 || a_acc[4] - a_acc[0] != 4) begin
        errors++;
        $display("FAIL basic_b2b got out span %0d acc span %0d want 4 4",
                 a_outc[4] - a_outc[0], a_acc[4] - a_acc[0]);
      end
    end
    checks++;
    if (a_cnt !== 16'd5) begin
      errors++; $display("FAIL basic_sample_count got %0d want 5", a_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] stim [5] = '{8'h00, 8'hE2, 8'hC3, 8'hF7, 8'hFF};
    int base;
    base = int'(a_cnt);
    a_smp.delete();
    foreach (stim[i]) a_smp.push_back(stim[i]);
    for (int i = 0; i < 8; i++) a_smp.push_back(8'($urandom_range(0, 255)));
    run_stream(2, 4);
    checks++;
    if (a_got.size() != a_smp.size()) begin
      errors++; $display("FAIL bp_count got %0d want %0d", a_got.size(), a_smp.size());
    end else begin
      for (int i = 0; i < a_smp.size(); i++) begin
        checks++;
        if (a_got[i] !== tbl_a[a_smp[i]]) begin
          errors++;
          $display("FAIL bp_data[%0d] addr %h got %0d want %0d", i, a_smp[i], a_got[i], tbl_a[a_smp[i]]);
        end
      end
    end
    checks++;
    if (!a_hold_ok || !a_saw_block) begin
      errors++; $display("FAIL bp_stall got hold_ok=%b in_ready_drop=%b want 1 1", a_hold_ok, a_saw_block);
    end
    checks++;
    if (a_cnt !== 16'(base + 13)) begin
      errors++; $display("FAIL bp_sample_count got %0d want %0d", a_cnt, base + 13);
    end
  endtask

  task automatic test_cfg_err();
    int w;
    write_a(8'h10, 2'd3);   // RUN: ignored, flags error
    checks++;
    if (a_err !== 1'b1) begin
      errors++; $display("FAIL err_set got %b want 1", a_err);
    end
    a_smp.delete(); a_smp.push_back(8'h10);
    run_stream(-1, 0);
    checks++;
    if (a_got.size() != 1 || a_got[0] !== tbl_a[8'h10] || a_got[0] !== 2'd0) begin
      errors++; $display("FAIL err_table_kept got %0d results first=%0d want 1 result of 0",
                         a_got.size(), (a_got.size() > 0) ? a_got[0] : 2'bx);
    end
    a_req = 1; tick(); a_req = 0;
    w = 0;
    while (a_mode !== 1'b1 && w < 20) begin tick(); w++; end
    checks++;
    if (a_mode !== 1'b1 || a_err !== 1'b1) begin
      errors++; $display("FAIL err_reconfig got mode=%b err=%b want 1 1", a_mode, a_err);
    end
    a_in_cfg = 1;
    pulse_done_a();
    checks++;
    if (a_err !== 1'b0 || a_mode !== 1'b0) begin
      errors++; $display("FAIL err_clear got err=%b mode=%b want 0 0", a_err, a_mode);
    end
  endtask

  task automatic test_drain();
    bit ok, bad;
    int got_n, c;
    logic [1:0] got [2];
    feed_two_stalled(8'hE2, 8'hC3, ok);
    a_req = 1; tick(); a_req = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_mode !== 1'b0 || ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1) bad = 1;
      tick();
    end
    checks++;
    if (!ok || bad) begin
      errors++; $display("FAIL drain_hold got fed=%b held_ok=%b want 1 1", ok, !bad);
    end
    ia.out_ready = 1;
    got_n = 0; c = 0;
    while (got_n < 2 && c < 10) begin
      #1;
      if (ia.out_valid) begin got[got_n] = ia.out_data; got_n++; end
      @(posedge clk); #1; c++;
    end
    checks++;
    if (got_n != 2 || got[0] !== tbl_a[8'hE2] || got[1] !== tbl_a[8'hC3]) begin
      errors++; $display("FAIL drain_flush got n=%0d %0d %0d want 2 %0d %0d",
                         got_n, got[0], got[1], tbl_a[8'hE2], tbl_a[8'hC3]);
    end
    checks++;
    if (a_mode !== 1'b0 || ia.out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_last got mode=%b valid=%b want 0 0", a_mode, ia.out_valid);
    end
    tick();
    checks++;
    if (a_mode !== 1'b1) begin
      errors++; $display("FAIL drain_to_cfg got mode=%b want 1", a_mode);
    end
    a_in_cfg = 1;
    write_a(8'hE2, 2'd2);
    pulse_done_a();
    a_smp.delete(); a_smp.push_back(8'hE2);
    run_stream(-1, 0);
    checks++;
    if (a_got.size() != 1 || a_got[0] !== 2'b10 || a_got[0] !== tbl_a[8'hE2]) begin
      errors++; $display("FAIL drain_rewrite got n=%0d val=%0d want 1 2",
                         a_got.size(), (a_got.size() > 0) ? a_got[0] : 2'bx);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    feed_two_stalled(8'hE2, 8'hF7, ok);
    #2 rst_n = 0;
    #1;
    checks++;
    if (!ok || ia.out_valid !== 1'b0 || a_cnt !== 16'd0 || a_mode !== 1'b1 || ia.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got fed=%b valid=%b cnt=%0d mode=%b ready=%b want 1 0 0 1 0",
               ok, ia.out_valid, a_cnt, a_mode, ia.in_ready);
    end
    @(negedge clk); rst_n = 1;
    tick();
    a_in_cfg = 1;
    ia.out_ready = 1;
    pulse_done_a();
    a_smp.delete(); a_smp.push_back(8'hC3);
    run_stream(-1, 0);
    checks++;
    if (a_got.size() != 1 || a_got[0] !== 2'd1 || a_got[0] !== tbl_a[8'hC3] || a_cnt !== 16'd1) begin
      errors++; $display("FAIL async_retain got n=%0d val=%0d cnt=%0d want 1 1 1",
                         a_got.size(), (a_got.size() > 0) ? a_got[0] : 2'bx, a_cnt);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_q [$];
    logic [3:0] e;
    int idx = 0, got_n = 0, c = 0, bad = 0;
    for (int a = 0; a < 512; a++) begin
      tbl_b[a] = 4'($urandom_range(0, 15));
      b_we = 1; b_addr = 9'(a); b_data = tbl_b[a];
      tick();
    end
    b_we = 0;
    b_done = 1; tick(); b_done = 0;
    while (got_n < 512 && c < 4000) begin
      ib.in_valid  = (idx < 512);
      ib.in_data   = 9'(idx);
      ib.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (ib.in_valid && ib.in_ready) begin exp_q.push_back(tbl_b[idx]); idx++; end
      if (ib.out_valid && ib.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        checks++;
        if (ib.out_data !== e) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL sweep_data[%0d] got %h want %h", got_n, ib.out_data, e);
        end
        got_n++;
      end
      @(posedge clk); #1; c++;
    end
    ib.in_valid = 0; ib.out_ready = 1;
    checks++;
    if (got_n != 512) begin
      errors++; $display("FAIL sweep_count got %0d want 512", got_n);
    end
    checks++;
    if (b_cnt !== 8'd0) begin
      errors++; $display("FAIL sweep_wrap got %0d want 0", b_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg_err();
    test_drain();
    test_async_reset();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_neuron_stream.md
Name: lut_neuron_stream

Overview:
Runtime-reprogrammable, pipelined successor to the fixed combinational LUT neuron. The truth table is loaded at run time through a config port instead of being baked into a case ROM, and is then applied to a valid/ready sample stream. Fan-in, input precision and output precision are parameters. It sits between quantised activation streams in the generated layer netlists, so table contents can be swapped without resynthesis.

Parameters:
FAN_IN, 4, number of quantised inputs per neuron
IN_BITS, 2, bits per input
OUT_BITS, 2, bits of output activation
COUNT_W, 16, width of processed-sample counter
(derived, not overridable: ADDR_W = FAN_IN*IN_BITS; DEPTH = 2**ADDR_W)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  ADDR_W  packed inputs; input i occupies bits [i*IN_BITS +: IN_BITS]
in_valid  in  1  sample valid
in_ready  out  1  block accepts sample
out_data  out  OUT_BITS  table result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
cfg_we  in  1  table write strobe
cfg_addr  in  ADDR_W  table write address
cfg_data  in  OUT_BITS  table write data
cfg_done  in  1  pulse: leave CFG, start streaming
cfg_req  in  1  pulse: request reconfiguration
cfg_mode  out  1  high while in CFG state
cfg_err  out  1  sticky: write attempted outside CFG
sample_count  out  COUNT_W  results delivered since reset

Behaviour:
- Reset (async assert, sync-safe deassert use): state=CFG, stage valids=0, out_data=0, out_valid=0, in_ready=0, cfg_mode=1, cfg_err=0, sample_count=0. Table contents are NOT reset (distributed RAM); they are retained across reset. In-flight samples are discarded.
- FSM, three states:
  CFG: in_ready=0. cfg_we writes table[cfg_addr]<=cfg_data at the clock edge. cfg_done -> RUN next cycle. A write and cfg_done in the same cycle both take effect. cfg_req is ignored.
  RUN: streaming. cfg_req -> DRAIN. cfg_we is ignored and sets cfg_err. cfg_done is ignored.
  DRAIN: in_ready=0. Pipeline continues to flush under out_ready. When both stage valids are 0 -> CFG next cycle. cfg_we is ignored and sets cfg_err.
- cfg_err clears only on reset or on cfg_done accepted in CFG.
- Pipeline: two stages.
  S1 registers in_data on an in_valid&&in_ready handshake.
  S2 registers table[S1 addr] into out_data.
  adv2 = !s2_v || out_ready. s2 loads s1 contents when adv2; s2_v <= s1_v when adv2.
  adv1 = !s1_v || adv2.
  in_ready = (state==RUN) && adv1 (combinational from out_ready; accepted).
- Latency: 2 cycles from accept to out_valid when unstalled. Full throughput is 1 sample/cycle.
- out_data holds its value while out_valid&&!out_ready. out_data is unchanged when out_valid=0.
- No read/write hazard: writes occur only in CFG, where the pipeline is empty by construction.
- sample_count increments on each out_valid&&out_ready and wraps modulo 2**COUNT_W.
- Asserting reset mid-stream returns to CFG with empty pipeline. The table keeps its prior contents, so cfg_done with no writes resumes the old function.

Test Plan:
1. Reset, write table all 0 except [0xE2]=1, [0xC3]=1, [0xF7]=1; cfg_done; stream 0x00,0xE2,0xC3,0xF7,0xFF with out_ready=1 -> outputs 0,1,1,1,0, first out_valid 2 cycles after first accept, back-to-back thereafter; sample_count=5.
2. Same stream with out_ready held 0 for 4 cycles mid-stream -> in_ready drops after pipeline fills, out_data stable at held value, no loss/duplication, order preserved.
3. cfg_we at 0x10 while in RUN -> cfg_err=1, table[0x10] unchanged (lookup of 0x10 still 0). Next reconfig cycle cfg_done -> cfg_err=0.
4. cfg_req with 2 samples in flight and out_ready=0 -> state stays DRAIN, cfg_mode=0, in_ready=0. Release out_ready -> both results delivered, then cfg_mode=1 next cycle. Rewrite [0xE2]=2, cfg_done, input 0xE2 -> 2'b10.
5. Async rst_n pulse mid-stream with 2 samples in flight -> out_valid=0 immediately, sample_count=0, cfg_mode=1. cfg_done without writes, input 0xC3 -> 1 (table retained).
6. Parameter sweep FAN_IN=3, IN_BITS=3, OUT_BITS=4: write random table, stream all 512 addresses -> every result matches the model; sample_count wraps correctly with COUNT_W=8 (512 -> 0).
